stream_framer: RTL and testbench

Consumer-side stream endpoint that pulls pixels from an upstream valid/ready FIFO and re-emits them with raster position and frame markers (start-of-frame, end-of-line, end-of-frame) for the Sobel window logic downstream. Contains a two-entry registered output stage (main + skid), so every output, including `ready_o`, is driven from a flop. Column and row counters track raster position and wrap at frame boundaries. Full throughput is one pixel per cycle.

---
 rtl/stream_framer.sv | 134 +++++++++++++
 tb/tb_stream_framer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_framer.sv
// ============================================================================
// Module   : stream_framer
// Brief    : Registered valid/ready endpoint (main + skid) tagging pixels with
//            raster position and SOF/EOL/EOF markers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_framer #(
  parameter int WIDTH_P = 8,
  parameter int COLS_P  = 640,
  parameter int ROWS_P  = 480
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WIDTH_P-1:0]        data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [WIDTH_P-1:0]        data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      sof_o,
  output logic                      eol_o,
  output logic                      eof_o,
  output logic [$clog2(COLS_P)-1:0] col_o,
  output logic [$clog2(ROWS_P)-1:0] row_o
);

  localparam int CW = $clog2(COLS_P);
  localparam int RW = $clog2(ROWS_P);
  // Storage entry layout: {sof, eol, eof, row, col, data}
  localparam int PW = WIDTH_P + CW + RW + 3;
  localparam logic [CW-1:0] C_COL_LAST = CW'(COLS_P - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(ROWS_P - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_m_valid;
  logic [PW-1:0]   r_m_pkt;
  logic [PW-1:0]   r_s_pkt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;

  logic            w_acc;
  logic            w_xfer;
  logic            w_sof;
  logic            w_eol;
  logic            w_eof;
  logic [PW-1:0]   w_pkt;

  assign w_acc  = valid_i & r_ready;
  assign w_xfer = r_m_valid & ready_i;
  assign w_sof  = (r_col == '0) && (r_row == '0);
  assign w_eol  = (r_col == C_COL_LAST);
  assign w_eof  = w_eol && (r_row == C_ROW_LAST);
  assign w_pkt  = {w_sof, w_eol, w_eof, r_row, r_col, data_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_EMPTY;
      r_ready   <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_pkt   <= '0;
      r_s_pkt   <= '0;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      if (w_acc) begin
        if (r_col == C_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      case (r_state)
        ST_EMPTY: begin
          r_ready <= 1'b1;
          if (w_acc) begin
            r_m_pkt   <= w_pkt;
            r_m_valid <= 1'b1;
            r_state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          r_ready <= ~(w_acc & ~w_xfer);
          if (w_acc && w_xfer) begin
            r_m_pkt <= w_pkt;
          end else if (w_acc) begin
            r_s_pkt <= w_pkt;
            r_state <= ST_TWO;
          end else if (w_xfer) begin
            // Markers must read 0 whenever nothing is valid on the output
            r_m_valid          <= 1'b0;
            r_m_pkt[PW-1 -: 3] <= 3'b000;
            r_state            <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          r_ready <= w_xfer;
          if (w_xfer) begin
            r_m_pkt <= r_s_pkt;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_ready   <= 1'b0;
          r_m_valid <= 1'b0;
          r_m_pkt   <= '0;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_m_valid;
  assign data_o  = r_m_pkt[WIDTH_P-1:0];
  assign col_o   = r_m_pkt[WIDTH_P +: CW];
  assign row_o   = r_m_pkt[WIDTH_P+CW +: RW];
  assign eof_o   = r_m_pkt[PW-3];
  assign eol_o   = r_m_pkt[PW-2];
  assign sof_o   = r_m_pkt[PW-1];

endmodule

`default_nettype wire

// File: tb/tb_stream_framer.sv
// ============================================================================
// Module   : tb_stream_framer
// Brief    : Self-checking bench for stream_framer (4x3 and 2x2 raster instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 columns x 3 rows
  logic       a_rst = 1'b0, a_valid_i = 1'b0, a_ready_i = 1'b0;
  logic [7:0] a_data_i = '0;
  logic       a_ready_o, a_valid_o, a_sof, a_eol, a_eof;
  logic [7:0] a_data_o;
  logic [1:0] a_col, a_row;

  stream_framer #(.WIDTH_P(8), .COLS_P(4), .ROWS_P(3)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .data_i(a_data_i), .valid_i(a_valid_i),
    .ready_o(a_ready_o), .data_o(a_data_o), .valid_o(a_valid_o),
    .ready_i(a_ready_i), .sof_o(a_sof), .eol_o(a_eol), .eof_o(a_eof),
    .col_o(a_col), .row_o(a_row)
  );

  // Instance B: 2 columns x 2 rows (wrap stress)
  logic       b_rst = 1'b0, b_valid_i = 1'b0, b_ready_i = 1'b0;
  logic [7:0] b_data_i = '0;
  logic       b_ready_o, b_valid_o, b_sof, b_eol, b_eof;
  logic [7:0] b_data_o;
  logic [0:0] b_col, b_row;

  stream_framer #(.WIDTH_P(8), .COLS_P(2), .ROWS_P(2)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .data_i(b_data_i), .valid_i(b_valid_i),
    .ready_o(b_ready_o), .data_o(b_data_o), .valid_o(b_valid_o),
    .ready_i(b_ready_i), .sof_o(b_sof), .eol_o(b_eol), .eof_o(b_eof),
    .col_o(b_col), .row_o(b_row)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted beats, tags derived from accept index
  typedef struct {
    int data;
    int col;
    int row;
    bit sof;
    bit eol;
    bit eof;
  } beat_t;

  beat_t q[$];
  int    a_acc_cnt = 0;
  bit    a_acc, a_xfer;
  int    a_acc_data;

  task automatic sample_a();
    @(negedge clk);
    chk("ready_o", {31'd0, a_ready_o}, {31'd0, (q.size() < 2)});
    chk("valid_o", {31'd0, a_valid_o}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      chk("data_o", {24'd0, a_data_o}, q[0].data);
      chk("col_o",  {30'd0, a_col},    q[0].col);
      chk("row_o",  {30'd0, a_row},    q[0].row);
      chk("sof_o",  {31'd0, a_sof},    {31'd0, q[0].sof});
      chk("eol_o",  {31'd0, a_eol},    {31'd0, q[0].eol});
      chk("eof_o",  {31'd0, a_eof},    {31'd0, q[0].eof});
    end else begin
      chk("idle_flags", {29'd0, a_sof, a_eol, a_eof}, 0);
    end
    a_acc      = a_valid_i & a_ready_o;
    a_xfer     = a_valid_o & a_ready_i;
    a_acc_data = a_data_i;
  endtask

  task automatic advance_a();
    beat_t b;
    int    idx;
    @(posedge clk);
    #1;
    if (a_xfer && q.size() > 0) q.delete(0);
    if (a_acc) begin
      idx    = a_acc_cnt % 12;
      b.data = a_acc_data;
      b.col  = idx % 4;
      b.row  = idx / 4;
      b.sof  = (idx == 0);
      b.eol  = (idx % 4 == 3);
      b.eof  = (idx == 11);
      q.push_back(b);
      a_acc_cnt++;
    end
  endtask

  task automatic step_a();
    sample_a();
    advance_a();
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, a_valid_o}, 0);
    chk("rst_ready", {31'd0, a_ready_o}, 0);
    chk("rst_data",  {24'd0, a_data_o}, 0);
    chk("rst_flags", {29'd0, a_sof, a_eol, a_eof}, 0);
    chk("rst_pos",   {28'd0, a_col, a_row}, 0);
    q.delete();
    a_acc_cnt = 0;
    @(posedge clk);
    #1;
    a_rst     = 1'b0;
    a_valid_i = 1'b1;
    a_data_i  = 8'hEE;
    a_ready_i = 1'b1;
    @(negedge clk);
    chk("rel_ready_low", {31'd0, a_ready_o}, 0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", {31'd0, a_ready_o}, 1);
    chk("rel_no_accept", {31'd0, a_valid_o}, 0);
    a_valid_i = 1'b0;
  endtask

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic       esof, eeol, eeof;
    logic       er;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int   p, low, nacc;
    logic [7:0] d, snap;

    for (int k = 0; k < 16; k++) begin
      p = k - 1;
      tbl[k].vin  = (k < 13);
      tbl[k].din  = 8'(k);
      tbl[k].ev   = (k >= 1 && k <= 13);
      tbl[k].ed   = 8'(p);
      tbl[k].esof = (p % 12 == 0);
      tbl[k].eeol = (p % 4 == 3);
      tbl[k].eeof = (p % 12 == 11);
      tbl[k].er   = 1'b1;
    end

    #1;
    b_rst = 1'b1;
    #1;
    chk("b_rst_valid", {31'd0, b_valid_o}, 0);
    chk("b_rst_ready", {31'd0, b_ready_o}, 0);
    b_rst = 1'b0;
    reset_a();

    // Wrap stress on the 2x2 instance: 10+ frames back to back
    b_valid_i = 1'b1;
    b_ready_i = 1'b1;
    for (int k = 0; k < 42; k++) begin
      b_data_i = 8'(k);
      @(negedge clk);
      chk("b_ready", {31'd0, b_ready_o}, 1);
      if (k >= 1) begin
        p = k - 1;
        chk("b_valid", {31'd0, b_valid_o}, 1);
        chk("b_data",  {24'd0, b_data_o}, p);
        chk("b_col",   {31'd0, b_col}, p % 2);
        chk("b_row",   {31'd0, b_row}, (p / 2) % 2);
        chk("b_sof",   {31'd0, b_sof}, {31'd0, (p % 4 == 0)});
        chk("b_eol",   {31'd0, b_eol}, {31'd0, (p % 2 == 1)});
        chk("b_eof",   {31'd0, b_eof}, {31'd0, (p % 4 == 3)});
      end else begin
        chk("b_valid0", {31'd0, b_valid_o}, 0);
      end
      @(posedge clk);
      #1;
    end
    b_valid_i = 1'b0;

    // Streaming table on instance A
    a_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a_valid_i = tbl[k].vin;
      a_data_i  = tbl[k].din;
      sample_a();
      chk("tbl_valid", {31'd0, a_valid_o}, {31'd0, tbl[k].ev});
      chk("tbl_ready", {31'd0, a_ready_o}, {31'd0, tbl[k].er});
      if (tbl[k].ev) begin
        chk("tbl_data", {24'd0, a_data_o}, {24'd0, tbl[k].ed});
        chk("tbl_sof",  {31'd0, a_sof}, {31'd0, tbl[k].esof});
        chk("tbl_eol",  {31'd0, a_eol}, {31'd0, tbl[k].eeol});
        chk("tbl_eof",  {31'd0, a_eof}, {31'd0, tbl[k].eeof});
      end
      advance_a();
    end

    // Backpressure: 5 stalled cycles mid-stream
    d = 8'h40;
    a_valid_i = 1'b1;
    a_ready_i = 1'b1;
    repeat (3) begin
      a_data_i = d;
      sample_a();
      if (a_acc) d++;
      advance_a();
    end
    a_ready_i = 1'b0;
    low  = 0;
    snap = '0;
    for (int s = 0; s < 5; s++) begin
      a_data_i = d;
      sample_a();
      if (!a_ready_o) low++;
      if (s == 1) snap = a_data_o;
      if (s == 4) chk("stall_hold", {24'd0, a_data_o}, {24'd0, snap});
      if (a_acc) d++;
      advance_a();
    end
    chk("stall_low_cycles", low, 4);
    chk("stall_depth", q.size(), 2);
    a_ready_i = 1'b1;
    a_data_i  = d;
    sample_a();
    chk("release_r1", {31'd0, a_ready_o}, 0);
    if (a_acc) d++;
    advance_a();
    a_data_i = d;
    sample_a();
    chk("release_r2", {31'd0, a_ready_o}, 1);
    advance_a();
    a_valid_i = 1'b0;
    repeat (3) step_a();

    // Random valid/ready over several frames
    nacc = 0;
    for (int c = 0; c < 600; c++) begin
      a_valid_i = 1'($urandom_range(0, 1));
      a_ready_i = 1'($urandom_range(0, 1));
      a_data_i  = 8'($urandom_range(0, 255));
      sample_a();
      if (a_acc) nacc++;
      advance_a();
    end
    a_valid_i = 1'b0;
    a_ready_i = 1'b1;
    repeat (4) step_a();
    chk("rand_accepts", {31'd0, (nacc >= 36)}, 1);
    chk("rand_drained", q.size(), 0);

    // Bubble input
    a_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      a_valid_i = (k % 2 == 0);
      a_data_i  = 8'(k + 100);
      step_a();
    end

    // Fill both entries, then reset asynchronously mid-cycle
    a_valid_i = 1'b1;
    a_ready_i = 1'b0;
    repeat (3) begin
      a_data_i = 8'($urandom_range(0, 255));
      step_a();
    end
    chk("two_depth", q.size(), 2);
    #2;
    reset_a();
    a_ready_i = 1'b1;
    a_valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a_data_i = 8'(200 + k);
      step_a();
    end
    a_valid_i = 1'b0;
    repeat (2) step_a();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
